// File: rtl/custom_logic_pkg.sv
// Shared definitions for the conditional-XOR link coder (custom_logic / custom_logic_decoder).
package custom_logic_pkg;

  localparam int BYTE_W = 8;

  // The coder is its own inverse: XOR with the key, then invert all bits when key[7] is set.
  function automatic logic [BYTE_W-1:0] cl_decode(input logic [BYTE_W-1:0] key,
                                                  input logic [BYTE_W-1:0] c);
    return c ^ key ^ {BYTE_W{key[BYTE_W-1]}};
  endfunction

  function automatic logic [BYTE_W-1:0] cl_encode(input logic [BYTE_W-1:0] key,
                                                  input logic [BYTE_W-1:0] b);
    return b ^ key ^ {BYTE_W{key[BYTE_W-1]}};
  endfunction

endpackage

// File: rtl/cl_pipe_stage.sv
// Single valid/ready register slice. Holds its payload stable while valid and not accepted.
module cl_pipe_stage #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_payload,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_payload
);

  logic         valid_q, valid_d;
  logic [W-1:0] payload_q, payload_d;

  // Handshake: a transfer happens on a rising edge where valid and ready are both 1.
  assign in_ready = !valid_q | out_ready;

  always_comb begin
    valid_d   = valid_q;
    payload_d = payload_q;
    if (in_ready) begin
      valid_d = in_valid;
      if (in_valid) payload_d = in_payload;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_payload = payload_q;

endmodule

// File: rtl/custom_logic_decoder.sv
// Streaming conditional-XOR decoder: key register with optional per-byte roll,
// two-slice valid/ready pipeline, and a delivered-byte counter.
module custom_logic_decoder
  import custom_logic_pkg::*;
#(
  parameter logic [7:0] KEY_RESET = 8'h00,
  parameter logic [7:0] KEY_STEP  = 8'h01,
  parameter int         CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_load,
  input  logic [7:0]       key_in,
  input  logic             roll_en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic [CNT_W-1:0] byte_count,
  output logic             busy
);

  logic [BYTE_W-1:0] key_q, key_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic                s1_valid, s2_valid, s2_in_ready;
  logic [2*BYTE_W-1:0] s1_payload;
  logic [BYTE_W-1:0]   s2_data_in;
  logic                accept;

  assign accept = in_valid & in_ready;

  // Stage 1 captures the key alongside the byte so later key changes cannot touch it.
  cl_pipe_stage #(.W(2*BYTE_W)) u_s1 (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_payload  ({key_q, in_data}),
    .out_valid   (s1_valid),
    .out_ready   (s2_in_ready),
    .out_payload (s1_payload)
  );

  assign s2_data_in = cl_decode(s1_payload[2*BYTE_W-1:BYTE_W], s1_payload[BYTE_W-1:0]);

  cl_pipe_stage #(.W(BYTE_W)) u_s2 (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (s1_valid),
    .in_ready    (s2_in_ready),
    .in_payload  (s2_data_in),
    .out_valid   (s2_valid),
    .out_ready   (out_ready),
    .out_payload (out_data)
  );

  always_comb begin
    key_d = key_q;
    if (key_load)               key_d = key_in;
    else if (accept && roll_en) key_d = key_q + KEY_STEP;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (s2_valid && out_ready) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_q <= KEY_RESET;
      cnt_q <= '0;
    end else begin
      key_q <= key_d;
      cnt_q <= cnt_d;
    end
  end

  assign out_valid  = s2_valid;
  assign byte_count = cnt_q;
  assign busy       = s1_valid | s2_valid;

endmodule

// File: tb/tb_custom_logic_decoder.sv
// Bench for custom_logic_decoder: directed plan steps plus a randomized phase,
// all checked against a queue-based behavioural model of held bytes.
module tb_custom_logic_decoder;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst, key_load, roll_en, in_valid, out_ready;
  logic [7:0]    key_in, in_data;
  logic          in_ready, out_valid, busy;
  logic [7:0]    out_data;
  logic [CW-1:0] byte_count;

  custom_logic_decoder #(.KEY_RESET(8'h00), .KEY_STEP(8'h01), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .key_load(key_load), .key_in(key_in), .roll_en(roll_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .byte_count(byte_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { logic [7:0] d; bit vis; } ent_t;
  ent_t        q[$];
  logic [7:0]  mkey;
  int unsigned mcnt;
  logic [7:0]  got_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ref_dec(input logic [7:0] k, input logic [7:0] c);
    logic [7:0] r;
    r = k ^ c;
    if (k >= 8'd128) r = ~r;
    return r;
  endfunction

  function automatic logic [7:0] ref_enc(input logic [7:0] k, input logic [7:0] b);
    logic [7:0] r;
    r = k ^ b;
    if (k >= 8'd128) r = ~r;
    return r;
  endfunction

  // One clock cycle: drive inputs, check in_ready, advance model across the edge, check outputs.
  task automatic cyc(input bit r, input bit kl, input logic [7:0] kv, input bit re,
                     input bit iv, input logic [7:0] d, input bit ordy);
    bit exp_ir, acc, deliv;
    logic [7:0] old_key;
    rst = r; key_load = kl; key_in = kv; roll_en = re;
    in_valid = iv; in_data = d; out_ready = ordy;
    #1;
    exp_ir = (q.size() < 2) || ordy;
    check("in_ready", {31'd0, in_ready}, {31'd0, exp_ir});
    acc   = iv && exp_ir;
    deliv = (q.size() > 0) && q[0].vis && ordy;
    if (deliv && !r) got_q.push_back(out_data);
    @(posedge clk);
    if (r) begin
      q.delete();
      mkey = 8'h00;
      mcnt = 0;
    end else begin
      old_key = mkey;
      if (deliv) begin
        void'(q.pop_front());
        mcnt++;
      end
      if (q.size() > 0 && !q[0].vis) q[0].vis = 1'b1;
      if (acc) q.push_back('{d: ref_dec(old_key, d), vis: 1'b0});
      if (kl) mkey = kv;
      else if (acc && re) mkey = mkey + 8'h01;
    end
    #1;
    check("out_valid", {31'd0, out_valid}, {31'd0, (q.size() > 0 && q[0].vis)});
    check("busy", {31'd0, busy}, {31'd0, (q.size() > 0)});
    check("byte_count", {28'd0, byte_count}, mcnt % (1 << CW));
    if (q.size() > 0 && q[0].vis) check("out_data", {24'd0, out_data}, {24'd0, q[0].d});
  endtask

  task automatic idle(input bit ordy);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, ordy);
  endtask

  task automatic load_key(input logic [7:0] k);
    cyc(1'b0, 1'b1, k, 1'b0, 1'b0, 8'h00, 1'b1);
  endtask

  task automatic send(input logic [7:0] d, input bit re, input bit ordy);
    cyc(1'b0, 1'b0, 8'h00, re, 1'b1, d, ordy);
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while (q.size() > 0 && budget < 10) begin
      idle(1'b1);
      budget++;
    end
    check("drain_timeout", q.size(), 0);
  endtask

  task automatic check_got(input string tag, input int idx, input logic [7:0] exp);
    if (idx < got_q.size()) check(tag, {24'd0, got_q[idx]}, {24'd0, exp});
    else check({tag, "_missing"}, got_q.size(), idx + 1);
  endtask

  initial begin
    q.delete();
    mkey = 8'h00;
    mcnt = 0;
    rst = 1'b1; key_load = 1'b0; key_in = 8'h00; roll_en = 1'b0;
    in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    @(posedge clk); #1;
    do_reset();
    do_reset();
    check("reset_out_data", {24'd0, out_data}, 32'h0);
    check("reset_out_valid", {31'd0, out_valid}, 32'h0);
    idle(1'b0);
    check("reset_in_ready", {31'd0, in_ready}, 32'h1);

    // Key 0x35, byte 0x5A: output appears on the second edge after presentation.
    load_key(8'h35);
    send(8'h5A, 1'b0, 1'b0);
    check("t1_latency_early", {31'd0, out_valid}, 32'h0);
    idle(1'b0);
    check("t1_latency_valid", {31'd0, out_valid}, 32'h1);
    check("t1_data", {24'd0, out_data}, 32'h6F);
    idle(1'b0);
    check("t1_hold", {24'd0, out_data}, 32'h6F);
    drain();

    // Key with bit 7 set inverts.
    got_q.delete();
    load_key(8'hA5);
    send(8'h0F, 1'b0, 1'b1);
    drain();
    check_got("t2_data", 0, 8'h55);
    if (got_q.size() > 0) check("t2_reencode", {24'd0, ref_enc(8'hA5, got_q[0])}, 32'h0F);

    // Rolling key across the 0x7F -> 0x80 boundary.
    got_q.delete();
    load_key(8'h7F);
    send(8'h00, 1'b1, 1'b1);
    send(8'h00, 1'b1, 1'b1);
    send(8'h00, 1'b0, 1'b1);
    drain();
    check_got("t3_b0", 0, 8'h7F);
    check_got("t3_b1", 1, 8'h7F);
    check_got("t3_key81", 2, 8'h7E);

    // Backpressure: two held, third waits until the sink opens up.
    do_reset();
    got_q.delete();
    send(8'h01, 1'b0, 1'b0);
    send(8'h02, 1'b0, 1'b0);
    send(8'h03, 1'b0, 1'b0);
    check("t4_in_ready_low", {31'd0, in_ready}, 32'h0);
    send(8'h03, 1'b0, 1'b1);
    drain();
    check_got("t4_b0", 0, 8'h01);
    check_got("t4_b1", 1, 8'h02);
    check_got("t4_b2", 2, 8'h03);
    check("t4_count", {28'd0, byte_count}, 32'd3);
    check("t4_busy", {31'd0, busy}, 32'h0);

    // key_load alongside acceptance uses the old key; reset drops in-flight bytes.
    do_reset();
    got_q.delete();
    cyc(1'b0, 1'b1, 8'h80, 1'b0, 1'b1, 8'h11, 1'b1);
    send(8'h11, 1'b0, 1'b1);
    drain();
    check_got("t5_b0", 0, 8'h11);
    check_got("t5_b1", 1, 8'h6E);
    send(8'h22, 1'b0, 1'b0);
    send(8'h33, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 8'h55, 1'b1, 1'b1, 8'h44, 1'b1);
    repeat (3) idle(1'b1);
    check("t5_flushed", {31'd0, out_valid}, 32'h0);
    check("t5_count_zero", {28'd0, byte_count}, 32'd0);
    got_q.delete();
    send(8'h00, 1'b0, 1'b1);
    drain();
    check_got("t5_key_reset", 0, 8'h00);

    // Counter wrap with a 4-bit counter.
    do_reset();
    for (int i = 0; i < 16; i++) send(8'(i), 1'b0, 1'b1);
    drain();
    check("t6_wrap16", {28'd0, byte_count}, 32'd0);
    send(8'hEE, 1'b0, 1'b1);
    drain();
    check("t6_wrap17", {28'd0, byte_count}, 32'd1);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 9) == 0, 8'($urandom),
          $urandom_range(0, 1) == 1, $urandom_range(0, 3) != 0, 8'($urandom),
          $urandom_range(0, 2) != 0);
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
